// File: rtl/axi_sram_arbiter_if.sv
// AXI3 master bus between the sram-like arbiter and the system interconnect.
// The master modport is the arbiter side; the slave modport is the memory/interconnect side.
interface axi_sram_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_arbiter.sv
// Bridges the inst-fetch and data sram-like ports onto one AXI3 master: independent read and
// write FSMs, data-over-inst read priority, and at most one outstanding data access.
module axi_sram_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  axi_sram_arbiter_if.master axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;

  rd_state_e   rd_state_q, rd_state_d;
  logic        rd_owner_q, rd_owner_d;   // 1 = data port owns the read
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_data_ok_q, inst_data_ok_d;
  logic        data_data_ok_q, data_data_ok_d;

  wr_state_e   wr_state_q, wr_state_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [1:0]  wr_size_q, wr_size_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        data_busy_q, data_busy_d;

  logic        data_rd_grant, inst_rd_grant, wr_grant;
  logic        rd_data_done, wr_data_done;
  logic [3:0]  strb_new;
  logic        unused_inputs;

  assign unused_inputs = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  always_comb begin
    data_rd_grant = (rd_state_q == R_IDLE) && data_req && !data_wr && !data_busy_q;
    inst_rd_grant = (rd_state_q == R_IDLE) && inst_req && !data_rd_grant;
    wr_grant      = (wr_state_q == W_IDLE) && data_req && data_wr && !data_busy_q;
  end

  always_comb begin
    unique case (data_size)
      2'd0:    strb_new = 4'b0001 << data_addr[1:0];
      2'd1:    strb_new = 4'b0011 << data_addr[1:0];
      default: strb_new = 4'b1111;
    endcase
  end

  // Read FSM
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_owner_d   = rd_owner_q;
    rd_addr_d    = rd_addr_q;
    rd_size_d    = rd_size_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    rd_data_done = 1'b0;
    inst_data_ok_d = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (data_rd_grant) begin
          rd_state_d = R_AR;
          rd_owner_d = 1'b1;
          rd_addr_d  = data_addr;
          rd_size_d  = data_size;
        end else if (inst_rd_grant) begin
          rd_state_d = R_AR;
          rd_owner_d = 1'b0;
          rd_addr_d  = inst_addr;
          rd_size_d  = 2'd2;
        end
      end
      R_AR: begin
        if (axi.arready) rd_state_d = R_R;
      end
      R_R: begin
        if (axi.rvalid && axi.rlast) begin
          rd_state_d = R_IDLE;
          if (rd_owner_q) begin
            data_rdata_d = axi.rdata;
            rd_data_done = 1'b1;
          end else begin
            inst_rdata_d   = axi.rdata;
            inst_data_ok_d = 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: the AW and W handshakes complete independently; both must finish before B.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_size_d    = wr_size_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wr_data_done = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (wr_grant) begin
          wr_state_d = W_ADDR;
          wr_addr_d  = data_addr;
          wr_size_d  = data_size;
          wr_data_d  = data_wdata;
          wr_strb_d  = strb_new;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_ADDR: begin
        aw_done_d = aw_done_q || axi.awready;
        w_done_d  = w_done_q || axi.wready;
        if (aw_done_d && w_done_d) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_RESP: begin
        if (axi.bvalid) begin
          wr_state_d   = W_IDLE;
          wr_data_done = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    data_data_ok_d = rd_data_done || wr_data_done;
    data_busy_d    = data_busy_q;
    if (data_addr_ok)        data_busy_d = 1'b1;
    else if (data_data_ok_q) data_busy_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q     <= R_IDLE;
      rd_owner_q     <= 1'b0;
      rd_addr_q      <= '0;
      rd_size_q      <= '0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      wr_state_q     <= W_IDLE;
      wr_addr_q      <= '0;
      wr_size_q      <= '0;
      wr_data_q      <= '0;
      wr_strb_q      <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      data_busy_q    <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      rd_owner_q     <= rd_owner_d;
      rd_addr_q      <= rd_addr_d;
      rd_size_q      <= rd_size_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      wr_state_q     <= wr_state_d;
      wr_addr_q      <= wr_addr_d;
      wr_size_q      <= wr_size_d;
      wr_data_q      <= wr_data_d;
      wr_strb_q      <= wr_strb_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      data_busy_q    <= data_busy_d;
    end
  end

  assign inst_addr_ok = inst_rd_grant;
  assign data_addr_ok = data_rd_grant || wr_grant;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign axi.arid    = rd_owner_q ? DATA_ID : INST_ID;
  assign axi.araddr  = rd_addr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = {1'b0, rd_size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = (rd_state_q == R_AR);
  assign axi.rready  = (rd_state_q == R_R);

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = wr_addr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = {1'b0, wr_size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = (wr_state_q == W_ADDR) && !aw_done_q;
  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wr_data_q;
  assign axi.wstrb   = wr_strb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (wr_state_q == W_ADDR) && !w_done_q;
  assign axi.bready  = (wr_state_q == W_RESP);

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Directed bench for axi_sram_arbiter; the bench itself plays the AXI slave cycle by cycle.
module tb_axi_sram_arbiter;
  logic        aclk;
  logic        aresetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int failures = 0;

  axi_sram_arbiter_if axi ();

  axi_sram_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .axi(axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Inst fetch: arready one cycle after accept, rvalid+rlast three cycles after that.
  task automatic inst_read_basic(input string p);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
    chk({p, "_addr_ok"}, 32'(inst_addr_ok), 32'd1);
    chk({p, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
    step(); inst_req = 1'b0; axi.arready = 1'b1; #1;
    chk({p, "_arvalid"}, 32'(axi.arvalid), 32'd1);
    chk({p, "_arid"}, 32'(axi.arid), 32'd0);
    chk({p, "_arsize"}, 32'(axi.arsize), 32'd2);
    chk({p, "_araddr"}, axi.araddr, 32'hBFC0_0000);
    chk({p, "_arlen"}, 32'(axi.arlen), 32'd0);
    chk({p, "_arburst"}, 32'(axi.arburst), 32'd1);
    step(); axi.arready = 1'b0; #1;
    chk({p, "_arvalid_drop"}, 32'(axi.arvalid), 32'd0);
    chk({p, "_rready"}, 32'(axi.rready), 32'd1);
    step(); #1;
    chk({p, "_no_early_ok"}, 32'(inst_data_ok), 32'd0);
    step(); axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h3C08_BFB0; #1;
    chk({p, "_ok_not_yet"}, 32'(inst_data_ok), 32'd0);
    step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk({p, "_data_ok"}, 32'(inst_data_ok), 32'd1);
    chk({p, "_rdata"}, inst_rdata, 32'h3C08_BFB0);
    chk({p, "_rready_low"}, 32'(axi.rready), 32'd0);
    step(); #1;
    chk({p, "_ok_pulse_end"}, 32'(inst_data_ok), 32'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    axi.arready = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

    repeat (3) step();
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    aresetn = 1'b1;
    step();

    // 1: basic inst fetch
    inst_read_basic("t1");

    // 2: simultaneous inst and data read; data wins, inst follows
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0010; #1;
    chk("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    step(); data_req = 1'b0; axi.arready = 1'b1; #1;
    chk("t2_arid", 32'(axi.arid), 32'd1);
    chk("t2_araddr", axi.araddr, 32'h8000_0010);
    chk("t2_inst_blocked_ar", 32'(inst_addr_ok), 32'd0);
    step(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'hDEAD_BEEF; #1;
    chk("t2_inst_blocked_r", 32'(inst_addr_ok), 32'd0);
    step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("t2_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t2_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("t2_inst_data_ok_quiet", 32'(inst_data_ok), 32'd0);
    chk("t2_inst_now_accepted", 32'(inst_addr_ok), 32'd1);
    step(); inst_req = 1'b0; axi.arready = 1'b1; #1;
    chk("t2_inst_arid", 32'(axi.arid), 32'd0);
    chk("t2_inst_araddr", axi.araddr, 32'hBFC0_0100);
    step(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h1122_3344; #1;
    step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("t2_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t2_inst_rdata", inst_rdata, 32'h1122_3344);
    step();

    // 3: byte store to lane 3
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000; #1;
    chk("t3_addr_ok", 32'(data_addr_ok), 32'd1);
    step(); data_req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; #1;
    chk("t3_awvalid", 32'(axi.awvalid), 32'd1);
    chk("t3_wvalid", 32'(axi.wvalid), 32'd1);
    chk("t3_awsize", 32'(axi.awsize), 32'd0);
    chk("t3_awaddr", axi.awaddr, 32'h8000_0003);
    chk("t3_wstrb", 32'(axi.wstrb), 32'h8);
    chk("t3_wlast", 32'(axi.wlast), 32'd1);
    chk("t3_wdata", axi.wdata, 32'hAB00_0000);
    chk("t3_awid", 32'(axi.awid), 32'd1);
    chk("t3_wid", 32'(axi.wid), 32'd1);
    chk("t3_bready_early", 32'(axi.bready), 32'd0);
    step(); axi.awready = 1'b0; axi.wready = 1'b0; #1;
    chk("t3_awvalid_drop", 32'(axi.awvalid), 32'd0);
    chk("t3_wvalid_drop", 32'(axi.wvalid), 32'd0);
    chk("t3_bready", 32'(axi.bready), 32'd1);
    axi.bvalid = 1'b1; #1;
    chk("t3_ok_not_yet", 32'(data_data_ok), 32'd0);
    step(); axi.bvalid = 1'b0; #1;
    chk("t3_data_data_ok", 32'(data_data_ok), 32'd1);
    step(); #1;
    chk("t3_ok_pulse_end", 32'(data_data_ok), 32'd0);

    // 4: word store, awready at T+1, wready at T+4
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0020; data_wdata = 32'h1234_5678; #1;
    chk("t4_addr_ok", 32'(data_addr_ok), 32'd1);
    step(); data_req = 1'b0; axi.awready = 1'b1; #1;
    chk("t4_awvalid_t1", 32'(axi.awvalid), 32'd1);
    chk("t4_wstrb", 32'(axi.wstrb), 32'hF);
    step(); axi.awready = 1'b0; #1;
    chk("t4_awvalid_t2", 32'(axi.awvalid), 32'd0);
    chk("t4_wvalid_t2", 32'(axi.wvalid), 32'd1);
    chk("t4_bready_t2", 32'(axi.bready), 32'd0);
    step(); #1;
    chk("t4_wvalid_t3", 32'(axi.wvalid), 32'd1);
    chk("t4_bready_t3", 32'(axi.bready), 32'd0);
    step(); axi.wready = 1'b1; #1;
    chk("t4_wvalid_t4", 32'(axi.wvalid), 32'd1);
    chk("t4_awvalid_t4", 32'(axi.awvalid), 32'd0);
    step(); axi.wready = 1'b0; #1;
    chk("t4_wvalid_t5", 32'(axi.wvalid), 32'd0);
    chk("t4_bready_t5", 32'(axi.bready), 32'd1);
    axi.bvalid = 1'b1;
    step(); axi.bvalid = 1'b0; #1;
    chk("t4_data_data_ok", 32'(data_data_ok), 32'd1);
    step();

    // 5: half store pending with slow B; data read blocked, inst read proceeds
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
    data_addr = 32'h8000_0042; data_wdata = 32'hBEEF_0000; #1;
    chk("t5_st_addr_ok", 32'(data_addr_ok), 32'd1);
    step(); data_req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; #1;
    chk("t5_wstrb", 32'(axi.wstrb), 32'hC);
    chk("t5_awsize", 32'(axi.awsize), 32'd1);
    step(); axi.awready = 1'b0; axi.wready = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0050;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200; #1;
    chk("t5_rd_blocked_0", 32'(data_addr_ok), 32'd0);
    chk("t5_inst_accept", 32'(inst_addr_ok), 32'd1);
    chk("t5_bready", 32'(axi.bready), 32'd1);
    step(); inst_req = 1'b0; axi.arready = 1'b1; #1;
    chk("t5_rd_blocked_1", 32'(data_addr_ok), 32'd0);
    chk("t5_inst_arid", 32'(axi.arid), 32'd0);
    step(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'hCAFE_F00D; #1;
    chk("t5_rd_blocked_2", 32'(data_addr_ok), 32'd0);
    step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("t5_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t5_inst_rdata", inst_rdata, 32'hCAFE_F00D);
    chk("t5_rd_blocked_3", 32'(data_addr_ok), 32'd0);
    step(); #1;
    chk("t5_rd_blocked_4", 32'(data_addr_ok), 32'd0);
    step(); axi.bvalid = 1'b1; #1;
    chk("t5_rd_blocked_5", 32'(data_addr_ok), 32'd0);
    step(); axi.bvalid = 1'b0; #1;
    chk("t5_st_data_ok", 32'(data_data_ok), 32'd1);
    chk("t5_rd_blocked_ok", 32'(data_addr_ok), 32'd0);
    step(); #1;
    chk("t5_rd_accept", 32'(data_addr_ok), 32'd1);
    chk("t5_arvalid_idle", 32'(axi.arvalid), 32'd0);
    step(); data_req = 1'b0; axi.arready = 1'b1; #1;
    chk("t5_rd_arid", 32'(axi.arid), 32'd1);
    chk("t5_rd_araddr", axi.araddr, 32'h8000_0050);
    step(); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = 32'h55AA_55AA; #1;
    step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("t5_rd_data_ok", 32'(data_data_ok), 32'd1);
    chk("t5_rd_rdata", data_rdata, 32'h55AA_55AA);
    step();

    // 6: reset asserted while the read waits in R_R
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300; #1;
    step(); inst_req = 1'b0; axi.arready = 1'b1; #1;
    step(); axi.arready = 1'b0; #1;
    chk("t6_rready_pre", 32'(axi.rready), 32'd1);
    aresetn = 1'b0; #1;
    chk("t6_rready_rst", 32'(axi.rready), 32'd0);
    chk("t6_arvalid_rst", 32'(axi.arvalid), 32'd0);
    chk("t6_awvalid_rst", 32'(axi.awvalid), 32'd0);
    chk("t6_wvalid_rst", 32'(axi.wvalid), 32'd0);
    chk("t6_bready_rst", 32'(axi.bready), 32'd0);
    chk("t6_inst_ok_rst", 32'(inst_data_ok), 32'd0);
    chk("t6_data_ok_rst", 32'(data_data_ok), 32'd0);
    chk("t6_inst_rdata_rst", inst_rdata, 32'h0);
    chk("t6_data_rdata_rst", data_rdata, 32'h0);
    step(); step();
    aresetn = 1'b1;
    step(); #1;
    chk("t6_no_stale_ok", 32'(inst_data_ok), 32'd0);
    chk("t6_rready_after", 32'(axi.rready), 32'd0);
    inst_read_basic("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
